// File: rtl/spi_master_if.sv
// Host request/response handshake plus SPI pins for spi_master.
interface spi_master_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [0:WIDTH-1] mdat;
    logic [0:WIDTH-1] sdat;
    logic             busy;
    logic             done;
    logic             ss;
    logic             sclk;
    logic             mosi;
    logic             miso;

    modport master (
        output start, mdat, miso,
        input  sdat, busy, done, ss, sclk, mosi
    );

    modport slave (
        input  start, mdat, miso,
        output sdat, busy, done, ss, sclk, mosi
    );
endinterface

// File: rtl/spi_master.sv
// Full-duplex MSB-first SPI initiator with parameterised width, SCLK divider and mode.
//
// state | meaning
// IDLE  | ss high, waiting for start
// SETUP | ss low, first bit on mosi, one half-period before the first edge
// SHIFT | generating the 2*WIDTH sclk edges
// HOLD  | sclk back at idle level, ss still low for one half-period
// GAP   | ss high for one half-period before the next start is accepted
module spi_master #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4,
    parameter bit CPOL  = 1'b0,
    parameter bit CPHA  = 1'b0
) (
    input logic         clk,
    input logic         reset,
    spi_master_if.slave bus
);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int EW = $clog2(2 * WIDTH);
    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [EW-1:0] EDGE_LAST = EW'(2 * WIDTH - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    div_cnt_q, div_cnt_d;
    logic [EW-1:0]    edge_cnt_q, edge_cnt_d;
    logic [0:WIDTH-1] tx_q, tx_d;
    logic [0:WIDTH-1] rx_q, rx_d;
    logic [0:WIDTH-1] sdat_q, sdat_d;
    logic             ss_q, ss_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div_wrap;
    logic             do_edge;

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        edge_cnt_d = edge_cnt_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        sdat_d     = sdat_q;
        ss_d       = ss_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_wrap   = (div_cnt_q == DIV_LAST);
        do_edge    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = SETUP;
                    div_cnt_d = '0;
                    tx_d      = bus.mdat;
                    rx_d      = '0;
                    ss_d      = 1'b0;
                    busy_d    = 1'b1;
                    mosi_d    = bus.mdat[0];
                    sclk_d    = CPOL;
                end
            end
            SETUP, SHIFT: begin
                div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
                if (div_wrap) begin
                    do_edge    = 1'b1;
                    state_d    = (edge_cnt_q == EDGE_LAST) ? HOLD : SHIFT;
                    edge_cnt_d = (edge_cnt_q == EDGE_LAST) ? '0 : edge_cnt_q + 1'b1;
                end
            end
            HOLD: begin
                div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
                if (div_wrap) begin
                    state_d = GAP;
                    ss_d    = 1'b1;
                    mosi_d  = 1'b0;
                    sdat_d  = rx_q;
                    done_d  = 1'b1;
                end
            end
            GAP: begin
                div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
                if (div_wrap) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Even edge index = leading edge; sample edge parity follows CPHA.
        if (do_edge) begin
            sclk_d = ~sclk_q;
            if (edge_cnt_q[0] == CPHA) begin
                for (int i = 0; i < WIDTH - 1; i++) rx_d[i] = rx_q[i + 1];
                rx_d[WIDTH - 1] = bus.miso;
            end else if (CPHA && edge_cnt_q == '0) begin
                mosi_d = tx_q[0];
            end else if (CPHA || edge_cnt_q != EDGE_LAST) begin
                for (int i = 0; i < WIDTH - 1; i++) tx_d[i] = tx_q[i + 1];
                tx_d[WIDTH - 1] = 1'b0;
                mosi_d = tx_d[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            edge_cnt_q <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            sdat_q     <= '0;
            ss_q       <= 1'b1;
            sclk_q     <= CPOL;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            sdat_q     <= sdat_d;
            ss_q       <= ss_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.sdat = sdat_q;
    assign bus.ss   = ss_q;
    assign bus.sclk = sclk_q;
    assign bus.mosi = mosi_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: instance A (W=8, DIV=4, mode 0) and instance B (W=16, DIV=1, mode 3).
module tb_spi_master;
    typedef struct {
        logic [15:0] sdat;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_a;
    logic reset_b;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;

    spi_master_if #(.WIDTH(8))  if_a ();
    spi_master_if #(.WIDTH(16)) if_b ();

    // miso source for A: 0 loopback, 1 tied low, 2 tied high, 3 slave model
    int         mode_a = 0;
    logic       slv_a = 1'b0;
    logic [7:0] slv_word_a = '0;
    int         sidx_a = 0;
    logic       prev_ss_s = 1'b1;
    logic       prev_sclk_s = 1'b0;

    assign if_a.miso = (mode_a == 0) ? if_a.mosi :
                       (mode_a == 1) ? 1'b0 :
                       (mode_a == 2) ? 1'b1 : slv_a;
    assign if_b.miso = if_b.mosi;

    spi_master #(.WIDTH(8), .DIV(4), .CPOL(1'b0), .CPHA(1'b0)) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (if_a)
    );

    spi_master #(.WIDTH(16), .DIV(1), .CPOL(1'b1), .CPHA(1'b1)) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (if_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bit          act_a = 1'b0, act_b = 1'b0;
    int          acc_a = 0, acc_b = 0;
    logic [15:0] word_a = '0, word_b = '0;
    logic [15:0] hold_a = '0, hold_b = '0;
    exp_t        q_a[$];
    exp_t        q_b[$];
    int          rise_a = 0, fall_a = 0, rise_b = 0, fall_b = 0;
    logic        prev_sclk_a = 1'b0, prev_sclk_b = 1'b1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, want %0h", name, cyc, got, want);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected {ss, sclk, mosi, busy} c cycles after ss first goes low.
    function automatic logic [3:0] exp_pins(input int w, input int dv, input bit cpol,
                                            input bit cpha, input logic [15:0] word,
                                            input bit act, input int c);
        int e;
        int idx;
        if (!act || c < 0 || c >= (2 * w + 2) * dv) return {1'b1, cpol, 1'b0, 1'b0};
        if (c >= (2 * w + 1) * dv) return {1'b1, cpol, 1'b0, 1'b1};
        e = c / dv;
        if (e > 2 * w) e = 2 * w;
        if (cpha) idx = (e == 0) ? 0 : (e - 1) / 2;
        else      idx = e / 2;
        if (idx > w - 1) idx = w - 1;
        return {1'b0, cpol ^ (e % 2 != 0), word[w - 1 - idx], 1'b1};
    endfunction

    function automatic logic [15:0] exp_word_a(input logic [7:0] w, input int md);
        case (md)
            0:       return {8'd0, w};
            1:       return 16'h0000;
            2:       return 16'h00FF;
            default: return {8'd0, slv_word_a};
        endcase
    endfunction

    // SPI slave for mode 0: presents bit 0 when ss falls, advances on each falling sclk.
    always @(negedge clk) begin
        if (prev_ss_s === 1'b1 && if_a.ss === 1'b0) begin
            sidx_a = 0;
            slv_a  = slv_word_a[7];
        end else if (if_a.ss === 1'b0 && prev_sclk_s === 1'b1 && if_a.sclk === 1'b0) begin
            sidx_a++;
            if (sidx_a < 8) slv_a = slv_word_a[7 - sidx_a];
        end
        prev_ss_s   = if_a.ss;
        prev_sclk_s = if_a.sclk;
    end

    always @(negedge clk) begin
        exp_t x;
        if (chk_en) begin
            chk("a_pins", {28'd0, if_a.ss, if_a.sclk, if_a.mosi, if_a.busy},
                {28'd0, exp_pins(8, 4, 1'b0, 1'b0, word_a, act_a, cyc - acc_a)});
            if (act_a && if_a.sclk !== prev_sclk_a) begin
                if (if_a.sclk) rise_a++;
                else           fall_a++;
            end
            prev_sclk_a = if_a.sclk;
            if (if_a.done === 1'b1) begin
                if (q_a.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL a_unexpected_done @cycle %0d: got done=1, want done=0", cyc);
                end else begin
                    x = q_a.pop_front();
                    chk("a_sdat", {24'd0, if_a.sdat}, {16'd0, x.sdat});
                    chk("a_done_cycle", cyc, x.cyc);
                    chk("a_rise_edges", rise_a, 8);
                    chk("a_fall_edges", fall_a, 8);
                    hold_a = x.sdat;
                end
                rise_a = 0;
                fall_a = 0;
            end else begin
                chk("a_sdat_hold", {24'd0, if_a.sdat}, {16'd0, hold_a});
            end
        end
    end

    always @(negedge clk) begin
        exp_t x;
        if (chk_en) begin
            chk("b_pins", {28'd0, if_b.ss, if_b.sclk, if_b.mosi, if_b.busy},
                {28'd0, exp_pins(16, 1, 1'b1, 1'b1, word_b, act_b, cyc - acc_b)});
            if (act_b && if_b.sclk !== prev_sclk_b) begin
                if (if_b.sclk) rise_b++;
                else           fall_b++;
            end
            prev_sclk_b = if_b.sclk;
            if (if_b.done === 1'b1) begin
                if (q_b.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL b_unexpected_done @cycle %0d: got done=1, want done=0", cyc);
                end else begin
                    x = q_b.pop_front();
                    chk("b_sdat", {16'd0, if_b.sdat}, {16'd0, x.sdat});
                    chk("b_done_cycle", cyc, x.cyc);
                    chk("b_rise_edges", rise_b, 16);
                    chk("b_fall_edges", fall_b, 16);
                    hold_b = x.sdat;
                end
                rise_b = 0;
                fall_b = 0;
            end else begin
                chk("b_sdat_hold", {16'd0, if_b.sdat}, {16'd0, hold_b});
            end
        end
    end

    task automatic wait_idle_a();
        int guard = 0;
        while (if_a.busy !== 1'b0 && guard < 200) begin
            cycles(1);
            guard++;
        end
        if (guard >= 200) begin
            n_chk++;
            n_fail++;
            $display("FAIL a_busy_timeout @cycle %0d: got busy=%b, want 0", cyc, if_a.busy);
        end
    endtask

    // Call right after a posedge; returns one cycle into the transfer (ss low).
    task automatic issue_a(input logic [7:0] w, input int md);
        wait_idle_a();
        mode_a     = md;
        slv_word_a = 8'($urandom);
        if_a.start = 1'b1;
        if_a.mdat  = w;
        cycles(1);
        if_a.start = 1'b0;
        if_a.mdat  = 8'($urandom);
        act_a  = 1'b1;
        acc_a  = cyc;
        word_a = {8'd0, w};
        q_a.push_back('{sdat: exp_word_a(w, md), cyc: cyc + 17 * 4});
    endtask

    task automatic wait_end_a();
        if (acc_a + 72 > cyc) cycles(acc_a + 72 - cyc);
    endtask

    task automatic issue_b(input logic [15:0] w);
        int guard = 0;
        while (if_b.busy !== 1'b0 && guard < 200) begin
            cycles(1);
            guard++;
        end
        if (guard >= 200) begin
            n_chk++;
            n_fail++;
            $display("FAIL b_busy_timeout @cycle %0d: got busy=%b, want 0", cyc, if_b.busy);
        end
        if_b.start = 1'b1;
        if_b.mdat  = w;
        cycles(1);
        if_b.start = 1'b0;
        if_b.mdat  = 16'($urandom);
        act_b  = 1'b1;
        acc_b  = cyc;
        word_b = w;
        q_b.push_back('{sdat: w, cyc: cyc + 33});
        cycles(34);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog @cycle %0d: got no finish, want finish", cyc);
        $fatal(1);
    end

    initial begin
        if_a.start = 1'b0;
        if_a.mdat  = '0;
        if_b.start = 1'b0;
        if_b.mdat  = '0;
        reset_a = 1'b1;
        reset_b = 1'b1;
        cycles(3);
        reset_a = 1'b0;
        reset_b = 1'b0;
        chk_en  = 1'b1;

        chk("a_rst_ss",   if_a.ss,   1);
        chk("a_rst_sclk", if_a.sclk, 0);
        chk("a_rst_mosi", if_a.mosi, 0);
        chk("a_rst_busy", if_a.busy, 0);
        chk("a_rst_done", if_a.done, 0);
        chk("a_rst_sdat", {24'd0, if_a.sdat}, 0);
        chk("b_rst_sclk", if_b.sclk, 1);
        chk("b_rst_ss",   if_b.ss,   1);
        cycles(2);

        issue_a(8'hA5, 0);
        wait_end_a();
        issue_a(8'h00, 2);
        wait_end_a();
        issue_a(8'($urandom), 1);
        wait_end_a();

        // back-to-back: start held high, second word taken in the busy-low cycle
        mode_a     = 0;
        if_a.start = 1'b1;
        if_a.mdat  = 8'h3C;
        cycles(1);
        act_a  = 1'b1;
        acc_a  = cyc;
        word_a = 16'h003C;
        q_a.push_back('{sdat: 16'h003C, cyc: cyc + 68});
        if_a.mdat = 8'hC3;
        cycles(73);
        if_a.start = 1'b0;
        act_a  = 1'b1;
        acc_a  = cyc;
        word_a = 16'h00C3;
        q_a.push_back('{sdat: 16'h00C3, cyc: cyc + 68});
        wait_end_a();

        // start pulse while busy must be ignored
        issue_a(8'h5A, 0);
        cycles(9);
        if_a.start = 1'b1;
        if_a.mdat  = 8'hFF;
        cycles(1);
        if_a.start = 1'b0;
        wait_end_a();
        cycles(3);

        // reset in the middle of a transfer
        issue_a(8'h66, 0);
        cycles(29);
        reset_a = 1'b1;
        cycles(1);
        reset_a = 1'b0;
        act_a   = 1'b0;
        hold_a  = '0;
        q_a.delete();
        rise_a  = 0;
        fall_a  = 0;
        chk("a_abort_ss",   if_a.ss,   1);
        chk("a_abort_sclk", if_a.sclk, 0);
        chk("a_abort_busy", if_a.busy, 0);
        chk("a_abort_done", if_a.done, 0);
        chk("a_abort_sdat", {24'd0, if_a.sdat}, 0);
        cycles(5);
        issue_a(8'h81, 0);
        wait_end_a();

        for (int i = 0; i < 20; i++) begin
            issue_a(8'($urandom), int'($urandom_range(0, 3)));
            wait_end_a();
            cycles(int'($urandom_range(0, 2)));
        end
        cycles(3);

        issue_b(16'h1234);
        for (int i = 0; i < 8; i++) begin
            issue_b(16'($urandom));
            cycles(int'($urandom_range(0, 2)));
        end
        cycles(4);

        chk("a_queue_empty", q_a.size(), 0);
        chk("b_queue_empty", q_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
Single-clock SPI initiator (master) that drives the slave-side devices (ADC1/2, DAC1/2) directly from fabric logic. This is the opposite end of the existing debug SPI slave and the SS/SCLK mux path.
- A host pulses `start` with a word; the block runs one full-duplex, MSB-first transfer with ss asserted low.
- It returns the received word with a one-cycle `done` strobe.
- SCLK rate, word width and SPI mode are parameters.

Parameters:
- WIDTH, 8, bits per transfer (≥1)
- DIV, 4, clk cycles per SCLK half-period (≥1)
- CPOL, 0, SCLK idle level
- CPHA, 0, 0 = sample on leading edge / shift on trailing edge; 1 = shift on leading edge / sample on trailing edge

Ports:
- clk  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high reset
- start  in  1  request a transfer; sampled only when busy=0
- mdat  in  [0:WIDTH-1]  word to send, bit 0 sent first
- sdat  out  [0:WIDTH-1]  last received word, bit 0 received first
- busy  out  1  high from the cycle after an accepted start until the transfer ends
- done  out  1  one-cycle pulse when sdat is valid
- ss  out  1  active-low slave select
- sclk  out  1  serial clock
- mosi  out  1  serial data out
- miso  in  1  serial data in

Behaviour:
- Reset (synchronous) forces the following on the next edge, including mid-transfer:
  - ss=1, sclk=CPOL, mosi=0, busy=0, done=0, sdat=0, state IDLE.
  - An aborted transfer produces no done pulse and leaves sdat=0.
- All outputs are registered; no combinational path from any input to any output.
- States: IDLE → SETUP → SHIFT → HOLD → GAP → IDLE.
- IDLE:
  - start=1 at cycle T latches mdat into the tx shift register and clears the rx shift register.
  - At T+1: ss=0, busy=1, mosi=mdat[0], sclk=CPOL; enter SETUP.
  - start is ignored whenever busy=1.
- SETUP: lasts DIV cycles, then enter SHIFT.
- SHIFT: 2·WIDTH SCLK edges, edge k (k=0..2W-1) at cycle T+1+DIV·(k+1).
  - Even k is a leading edge (sclk leaves CPOL); odd k is a trailing edge.
  - Sample edge: leading if CPHA=0, else trailing. On it, miso is shifted into the rx register.
  - Shift edge: trailing if CPHA=0, else leading. On it, mosi takes the next tx bit.
  - The CPHA=1 first leading edge re-drives bit 0.
  - No shift occurs after the final bit. mosi holds the last bit until HOLD ends.
- HOLD: after the last edge (T+1+2W·DIV), sclk=CPOL for DIV cycles.
- End of HOLD, at cycle T+1+(2W+1)·DIV:
  - ss=1, mosi=0.
  - sdat ← rx register; done=1 for exactly that cycle.
- GAP: ss stays high for DIV cycles with busy=1. busy=0 at T+1+(2W+2)·DIV.
  - A start asserted in that cycle is accepted (minimum ss-high time = DIV).
- Worked example, W=8, DIV=4: ss falls T+1, first edge T+5, last edge T+65, ss rises and done at T+69, busy low at T+73.
- Counters:
  - Divider counter ⌈log2(DIV)⌉ bits, wraps at DIV-1.
  - Edge counter ⌈log2(2W)⌉ bits.
  - Neither counter wraps while in IDLE.
- miso is sampled directly with no synchronizer; it is source-synchronous to sclk by construction.

Test Plan:
- Loopback (miso=mosi), WIDTH=8, DIV=4, CPOL=0, CPHA=0, mdat=0xA5:
  - mosi bits 1,0,1,0,0,1,0,1 valid at each rising sclk.
  - sdat=0xA5 with done at T+69; busy low at T+73.
  - Exactly 8 rising and 8 falling sclk edges.
- miso tied 1, mdat=0x00 → sdat=0xFF, mosi=0 throughout.
- miso tied 0 → sdat=0x00.
- Timing check:
  - ss low-to-first-edge = 4 cycles; SCLK period = 8 cycles; last-edge-to-ss-high = 4 cycles; ss-high gap ≥ 4 cycles.
  - Back-to-back start held high: transfers of 0x3C then 0xC3 both complete with two done pulses.
- Start pulses during busy (mdat=0xFF at T+10):
  - Ignored; the in-flight transfer of 0x5A completes unchanged and only one done pulse occurs.
- Reset at T+30 mid-transfer:
  - Next cycle ss=1, sclk=CPOL, busy=0, sdat=0, no done.
  - A new start afterwards with 0x81 in loopback completes correctly.
- Instance with CPOL=1, CPHA=1, WIDTH=16, DIV=1, loopback 0x1234:
  - sclk idles high.
  - Sampling occurs on rising (trailing) edges.
  - sdat=0x1234, done at T+1+33=T+34.
